prog_sequencer: RTL and testbench

//  Upstream driver of the processor top level. Launches a table of programs in order
//  by pulsing the core's start/start_addr inputs, then waits for the core's done flag.

---
 rtl/prog_sequencer.sv | 171 +++++++++++++++++
 tb/tb_prog_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Launches a table of programs on the core one after another and reports each program's run length.
// Optional feature: define PROG_SEQ_STATS_EN to add total_count_o, the saturating sum of all reported counts.
module prog_sequencer #(
    parameter int unsigned NUM_PROGS    = 3,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned START_CYCLES = 2,
    parameter int unsigned TIMEOUT      = 16'hFFFF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        go_i,
    input  logic [NUM_PROGS*ADDR_W-1:0] addr_table_i,
    input  logic                        done_i,
    output logic                        start_o,
    output logic [ADDR_W-1:0]           start_addr_o,
    output logic [3:0]                  prog_idx_o,
    output logic [CNT_W-1:0]            instr_count_o,
    output logic                        count_valid_o,
    output logic                        timed_out_o,
    output logic                        all_done_o
`ifdef PROG_SEQ_STATS_EN
    ,
    output logic [CNT_W+3:0]            total_count_o
`endif
);

    localparam int unsigned LCNT_W = $clog2(START_CYCLES + 1);
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned TOT_W  = CNT_W + 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_REPORT,
        S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d, idx_inc;
    logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                start_q, start_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    icount_q, icount_d;
    logic                valid_q, valid_d;
    logic                tout_q, tout_d;
    logic                alldone_q, alldone_d;
`ifdef PROG_SEQ_STATS_EN
    logic [TOT_W-1:0]    total_q, total_d;
    logic [TOT_W:0]      tot_sum;

    assign tot_sum = {1'b0, total_q} + (TOT_W+1)'(cnt_q);
`endif

    assign idx_inc = idx_q + IDX_W'(1);

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lcnt_d    = lcnt_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        addr_d    = addr_q;
        icount_d  = icount_q;
        valid_d   = 1'b0;
        tout_d    = tout_q;
        alldone_d = alldone_q;
`ifdef PROG_SEQ_STATS_EN
        total_d   = total_q;
`endif
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (go_i) begin
                    state_d   = S_LAUNCH;
                    idx_d     = '0;
                    lcnt_d    = '0;
                    start_d   = 1'b1;
                    addr_d    = addr_table_i[ADDR_W-1:0];
                    tout_d    = 1'b0;
                    alldone_d = 1'b0;
`ifdef PROG_SEQ_STATS_EN
                    total_d   = '0;
`endif
                end
            end
            S_LAUNCH: begin
                // Done is deliberately ignored while the core is held in start
                if (lcnt_q == LCNT_W'(START_CYCLES - 1)) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_W'(1);
                end else begin
                    lcnt_d  = lcnt_q + LCNT_W'(1);
                    start_d = 1'b1;
                end
            end
            S_RUN: begin
                if (done_i || (cnt_q == CNT_W'(TIMEOUT))) begin
                    state_d  = S_REPORT;
                    icount_d = cnt_q;
                    valid_d  = 1'b1;
                    if (!done_i) tout_d = 1'b1;
`ifdef PROG_SEQ_STATS_EN
                    total_d  = tot_sum[TOT_W] ? '1 : tot_sum[TOT_W-1:0];
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REPORT: begin
                if (idx_q == IDX_W'(NUM_PROGS - 1)) begin
                    state_d   = S_FINISH;
                    alldone_d = 1'b1;
                end else begin
                    state_d = S_LAUNCH;
                    idx_d   = idx_inc;
                    lcnt_d  = '0;
                    start_d = 1'b1;
                    addr_d  = addr_table_i[int'(idx_inc)*ADDR_W +: ADDR_W];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            lcnt_q    <= '0;
            cnt_q     <= '0;
            start_q   <= 1'b0;
            addr_q    <= '0;
            icount_q  <= '0;
            valid_q   <= 1'b0;
            tout_q    <= 1'b0;
            alldone_q <= 1'b0;
`ifdef PROG_SEQ_STATS_EN
            total_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lcnt_q    <= lcnt_d;
            cnt_q     <= cnt_d;
            start_q   <= start_d;
            addr_q    <= addr_d;
            icount_q  <= icount_d;
            valid_q   <= valid_d;
            tout_q    <= tout_d;
            alldone_q <= alldone_d;
`ifdef PROG_SEQ_STATS_EN
            total_q   <= total_d;
`endif
        end
    end

    assign start_o       = start_q;
    assign start_addr_o  = addr_q;
    assign prog_idx_o    = idx_q;
    assign instr_count_o = icount_q;
    assign count_valid_o = valid_q;
    assign timed_out_o   = tout_q;
    assign all_done_o    = alldone_q;
`ifdef PROG_SEQ_STATS_EN
    assign total_count_o = total_q;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a per-cycle expected timeline is built from program lengths, then compared every cycle.
// Covers PROG_SEQ_STATS_EN when the macro is defined for the build.
module tb_prog_sequencer;

    localparam int NP  = 3;
    localparam int AW  = 8;
    localparam int CW  = 16;
    localparam int SC  = 2;
    localparam int TO  = 10;
    localparam int NC  = 160;
    localparam int NF  = 8;
    localparam int F_START = 0, F_ADDR = 1, F_IDX = 2, F_ICNT = 3,
                   F_VALID = 4, F_TOUT = 5, F_ALLD = 6, F_TOT = 7;

    logic               clk = 1'b0;
    logic               rst_i, go_i, done_i;
    logic [NP*AW-1:0]   addr_table_i;
    logic               start_o, count_valid_o, timed_out_o, all_done_o;
    logic [AW-1:0]      start_addr_o;
    logic [3:0]         prog_idx_o;
    logic [CW-1:0]      instr_count_o;
`ifdef PROG_SEQ_STATS_EN
    logic [CW+3:0]      total_count_o;
`endif

    prog_sequencer #(
        .NUM_PROGS(NP), .ADDR_W(AW), .CNT_W(CW), .START_CYCLES(SC), .TIMEOUT(TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .go_i         (go_i),
        .addr_table_i (addr_table_i),
        .done_i       (done_i),
        .start_o      (start_o),
        .start_addr_o (start_addr_o),
        .prog_idx_o   (prog_idx_o),
        .instr_count_o(instr_count_o),
        .count_valid_o(count_valid_o),
        .timed_out_o  (timed_out_o),
        .all_done_o   (all_done_o)
`ifdef PROG_SEQ_STATS_EN
        ,
        .total_count_o(total_count_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int e [NF][NC];
    int obs [NF][NC];
    int go_s [NC];
    int done_s [NC];
    int rst_lvl [NC];
    int tbl [NP] = '{'h00, 'h20, 'h40};
    int got_cnt [$];

    task automatic chk(input string nm, input int c, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, got, exp);
        end
    endtask

    task automatic fill(input int f, input int from, input int v);
        for (int c = from; c < NC; c++) e[f][c] = v;
    endtask

    // Expected timeline of one run of the table launched by Go sampled at edge g.
    // len 0 = Done never comes; dil = Done also held high during program 0's launch.
    task automatic plan_run(input int g, input int l0, input int l1, input int l2, input bit dil);
        int lens [NP];
        int ln, k, r, sum;
        bit to;
        lens = '{l0, l1, l2};
        go_s[g] = 1;
        fill(F_TOUT, g, 0);
        fill(F_ALLD, g, 0);
        fill(F_TOT, g, 0);
        ln  = g;
        sum = 0;
        for (int j = 0; j < NP; j++) begin
            for (int c = ln; c < ln + SC; c++) e[F_START][c] = 1;
            fill(F_ADDR, ln, tbl[j]);
            fill(F_IDX, ln, j);
            if (j == 0 && dil) for (int c = ln + 1; c <= ln + SC; c++) done_s[c] = 1;
            to = (lens[j] == 0) || (lens[j] > TO);
            k  = to ? TO : lens[j];
            if (!to) done_s[ln + SC + k] = 1;
            r = ln + SC + k;
            e[F_VALID][r] = 1;
            fill(F_ICNT, r, k);
            if (to) fill(F_TOUT, r, 1);
            sum += k;
            fill(F_TOT, r, sum);
            ln = r + 1;
        end
        fill(F_ALLD, ln, 1);
    endtask

    // Reset driven from cycle r for n cycles: everything reads zero from the next cycle on.
    task automatic plan_reset(input int r, input int n);
        for (int c = r; c < r + n; c++) rst_lvl[c] = 1;
        for (int f = 0; f < NF; f++) fill(f, r + 1, 0);
        for (int c = r + 1; c < NC; c++) begin
            go_s[c]   = 0;
            done_s[c] = 0;
        end
    endtask

    // Compare process: every cycle after the edge, DUT outputs vs the timeline.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NC) begin
            obs[F_START][cyc] = int'(start_o);
            obs[F_ADDR][cyc]  = int'(start_addr_o);
            obs[F_IDX][cyc]   = int'(prog_idx_o);
            obs[F_ICNT][cyc]  = int'(instr_count_o);
            obs[F_VALID][cyc] = int'(count_valid_o);
            obs[F_TOUT][cyc]  = int'(timed_out_o);
            obs[F_ALLD][cyc]  = int'(all_done_o);
`ifdef PROG_SEQ_STATS_EN
            obs[F_TOT][cyc]   = int'(total_count_o);
            chk("total_count", cyc, obs[F_TOT][cyc], e[F_TOT][cyc]);
`endif
            chk("start", cyc, obs[F_START][cyc], e[F_START][cyc]);
            chk("start_addr", cyc, obs[F_ADDR][cyc], e[F_ADDR][cyc]);
            chk("prog_idx", cyc, obs[F_IDX][cyc], e[F_IDX][cyc]);
            chk("instr_count", cyc, obs[F_ICNT][cyc], e[F_ICNT][cyc]);
            chk("count_valid", cyc, obs[F_VALID][cyc], e[F_VALID][cyc]);
            chk("timed_out", cyc, obs[F_TOUT][cyc], e[F_TOUT][cyc]);
            chk("all_done", cyc, obs[F_ALLD][cyc], e[F_ALLD][cyc]);
            if (count_valid_o) got_cnt.push_back(int'(instr_count_o));
        end
    end

    initial begin
        int lit [13] = '{5, 5, 9, 1, 1, 10, 10, 10, 10, 10, 3, 2, 4};
        rst_i  = 1'b1;
        go_i   = 1'b0;
        done_i = 1'b0;
        addr_table_i = {8'h40, 8'h20, 8'h00};
        for (int f = 0; f < NF; f++) fill(f, 0, 0);
        for (int c = 0; c < NC; c++) begin
            go_s[c] = 0; done_s[c] = 0; rst_lvl[c] = 0;
        end
        rst_lvl[0] = 1;
        rst_lvl[1] = 1;
        plan_run(3, 5, 9, 1, 1'b0);      // aborted by reset during program 1's RUN
        plan_reset(16, 3);
        plan_run(22, 5, 9, 1, 1'b0);
        go_s[35] = 1;                    // Go during RUN must be ignored
        plan_run(50, 1, 10, 0, 1'b1);    // Done through launch; Done coinciding with timeout; real timeout
        plan_run(85, 0, 0, 0, 1'b0);
        plan_run(130, 3, 2, 4, 1'b0);

        while (cyc < NC) begin
            @(negedge clk);
            #1;
            if (cyc < NC) rst_i = rst_lvl[cyc][0];
            go_i   = (cyc + 1 < NC) ? go_s[cyc + 1][0] : 1'b0;
            done_i = (cyc + 1 < NC) ? done_s[cyc + 1][0] : 1'b0;
        end
        #2;

        // Hand-computed pins on the model and the DUT
        chk("strobe_count", 0, got_cnt.size(), 13);
        for (int i = 0; i < 13; i++)
            chk("strobe_value", i, (i < got_cnt.size()) ? got_cnt[i] : -1, lit[i]);
        chk("reset_addr", 17, obs[F_ADDR][17], 0);
        chk("reset_valid_pending", 22, obs[F_VALID][22], 0);
        chk("first_start", 22, obs[F_START][22], 1);
        chk("start_len", 24, obs[F_START][24], 0);
        chk("third_addr", 42, obs[F_ADDR][42], 'h40);
        chk("all_done_B", 46, obs[F_ALLD][46], 1);
        chk("timed_out_B", 46, obs[F_TOUT][46], 0);
        chk("done_at_timeout_cnt", 66, obs[F_ICNT][66], 10);
        chk("done_at_timeout_flag", 66, obs[F_TOUT][66], 0);
        chk("timeout_cleared", 96, obs[F_TOUT][96], 0);
        chk("timeout_set", 97, obs[F_TOUT][97], 1);
        chk("relaunch_addr", 130, obs[F_ADDR][130], 0);
        chk("relaunch_all_done", 130, obs[F_ALLD][130], 0);
`ifdef PROG_SEQ_STATS_EN
        chk("total_B", 46, obs[F_TOT][46], 15);
        chk("total_D", 124, obs[F_TOT][124], 30);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
